// File: rtl/program_counter_unit.sv
// Program counter unit: holds the fetch PC and selects seq / branch / JAL / JALR next PC.
// Latency: the new PC appears one cycle after the edge that samples Sel_PC. PC_Plus4 follows PC combinationally.
// Backpressure: Stall freezes PC and Instr_Count. Halt_Req parks the unit until reset. Misaligned targets trap.
module program_counter_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Offset_J,
  input  logic [31:0] Offset_B,
  input  logic [31:0] Target_R,
  input  logic [1:0]  Sel_PC,
  input  logic        Branch_Taken,
  input  logic        Stall,
  input  logic        Halt_Req,
  output logic [31:0] PC,
  output logic [31:0] PC_Plus4,
  output logic        Fetch_Valid,
  output logic        Misaligned,
  output logic [31:0] Trap_PC,
  output logic [31:0] Instr_Count,
  output logic [1:0]  State
);

  // The state encoding is visible on the State port, so the values are fixed.
  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_TRAP = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  // Sel_PC encodings.
  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JAL    = 2'b10;
  localparam logic [1:0] SEL_JALR   = 2'b11;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic        fetch_vld_q, fetch_vld_d;
  logic        misaligned_q, misaligned_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jal_target;
  logic [31:0] jalr_target;
  logic [31:0] next_target;
  logic        target_misaligned;

  // All adders wrap modulo 2^32. There is deliberately no overflow detection.
  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = pc_q + Offset_B;
  // The J immediate arrives in halfword units, so it is scaled to bytes here.
  assign jal_target    = pc_q + (Offset_J << 1);
  // JALR clears bit 0 of the ALU result. Bit 1 can still be set, and that case traps.
  assign jalr_target   = Target_R & ~32'h1;

  // Select the candidate next PC from Sel_PC. A not-taken branch falls through to PC+4.
  always_comb begin
    next_target = pc_plus4;
    case (Sel_PC)
      SEL_SEQ:    next_target = pc_plus4;
      SEL_BRANCH: next_target = Branch_Taken ? branch_target : pc_plus4;
      SEL_JAL:    next_target = jal_target;
      SEL_JALR:   next_target = jalr_target;
      default:    next_target = pc_plus4;
    endcase
  end

  // With 32-bit instructions, any target that is not word aligned is illegal.
  assign target_misaligned = |next_target[1:0];

  // Next-state logic. Every register holds unless a rule below changes it.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    trap_pc_d    = trap_pc_q;
    instr_cnt_d  = instr_cnt_q;
    fetch_vld_d  = fetch_vld_q;
    misaligned_d = 1'b0;

    case (state_q)
      // The first fetch is the reset vector itself, so PC is not advanced on leaving BOOT.
      ST_BOOT: begin
        state_d     = ST_RUN;
        fetch_vld_d = 1'b1;
      end

      // Priority: stall, then halt, then the trap check, then a normal advance.
      ST_RUN: begin
        if (Stall) begin
          fetch_vld_d = 1'b1;
        end else if (Halt_Req) begin
          state_d     = ST_HALT;
          fetch_vld_d = 1'b0;
        end else if (target_misaligned) begin
          state_d      = ST_TRAP;
          pc_d         = TRAP_VECTOR;
          trap_pc_d    = next_target;
          misaligned_d = 1'b1;
          fetch_vld_d  = 1'b0;
        end else begin
          pc_d        = next_target;
          instr_cnt_d = instr_cnt_q + 32'd1;
        end
      end

      // The trap lasts a single cycle. Fetch resumes from the trap vector and inputs are ignored.
      ST_TRAP: begin
        state_d     = ST_RUN;
        fetch_vld_d = 1'b1;
      end

      // HALT is absorbing. Only reset leaves it.
      ST_HALT: begin
        fetch_vld_d = 1'b0;
      end

      default: begin
        state_d     = ST_BOOT;
        pc_d        = RESET_VECTOR;
        fetch_vld_d = 1'b0;
      end
    endcase
  end

  // State registers. Synchronous reset overrides every other input in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VECTOR;
      trap_pc_q    <= 32'h0;
      instr_cnt_q  <= 32'h0;
      fetch_vld_q  <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      trap_pc_q    <= trap_pc_d;
      instr_cnt_q  <= instr_cnt_d;
      fetch_vld_q  <= fetch_vld_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign PC          = pc_q;
  assign PC_Plus4    = pc_plus4;
  assign Fetch_Valid = fetch_vld_q;
  assign Misaligned  = misaligned_q;
  assign Trap_PC     = trap_pc_q;
  assign Instr_Count = instr_cnt_q;
  assign State       = state_q;

endmodule
